// File: rtl/gb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gb_bus_pkg
// Brief   : Shared bus constants, DMA state encoding and page-folding helper.
// Revision: 1.0 - initial release
// ============================================================================
package gb_bus_pkg;

  localparam logic [15:0] REG_DMA     = 16'hFF46;
  localparam logic [15:0] OAM_BASE    = 16'hFE00;
  localparam int          OAM_SIZE    = 160;
  localparam logic [7:0]  ECHO_START  = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET = 8'h20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } dma_state_t;

  // Pages in the echo region mirror work RAM 0x20 pages lower.
  function automatic logic [7:0] fold_page(input logic [7:0] page);
    return (page >= ECHO_START) ? (page - ECHO_OFFSET) : page;
  endfunction

endpackage
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module  : oam_dma
// Brief   : Sprite attribute DMA engine. A write to the page register copies
//           N_BYTES bytes from {page,00} into OAM, one byte per two cycles.
// Revision: 1.0 - initial release
// ============================================================================
module oam_dma #(
  parameter int          N_BYTES     = gb_bus_pkg::OAM_SIZE,
  parameter int          START_DELAY = 1,
  parameter logic [15:0] REG_ADDR    = gb_bus_pkg::REG_DMA,
  parameter logic [15:0] OAM_BASE    = gb_bus_pkg::OAM_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Do_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  output logic        cs_reg,
  output logic [7:0]  Di_reg,
  output logic [15:0] A_src,
  output logic        rd_src,
  input  logic [7:0]  Do_src,
  output logic [15:0] A_oam,
  output logic [7:0]  Di_oam,
  output logic        wr_oam,
  output logic        busy,
  output logic        done
);
  import gb_bus_pkg::*;

  localparam int IDX_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int DLY_W = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(START_DELAY);

  dma_state_t       state, state_d;
  logic [7:0]       page_reg, page_d;
  logic [IDX_W-1:0] idx, idx_d;
  logic [DLY_W-1:0] cnt, cnt_d;
  logic [7:0]       latch, latch_d;
  logic             fin, fin_d;
  logic             trig;

  assign trig = wr_cpu && (A_cpu == REG_ADDR);

  // Next-state and datapath updates; a register write overrides everything.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    latch_d = latch;
    page_d  = page_reg;
    fin_d   = 1'b0;
    case (state)
      START: begin
        cnt_d = cnt - DLY_W'(1);
        if (cnt_d == '0) state_d = READ;
      end
      READ: begin
        latch_d = Do_src;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx == LAST_IDX) begin
          state_d = IDLE;
          fin_d   = 1'b1;
        end else begin
          idx_d   = idx + IDX_W'(1);
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    if (trig) begin
      page_d  = Do_cpu;
      idx_d   = '0;
      cnt_d   = DLY_INIT;
      fin_d   = 1'b0;
      state_d = (START_DELAY == 0) ? READ : START;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Page, index, delay counter, data latch and the delayed done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_reg <= 8'h00;
      idx      <= '0;
      cnt      <= '0;
      latch    <= 8'h00;
      fin      <= 1'b0;
      done     <= 1'b0;
    end else begin
      page_reg <= page_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      latch    <= latch_d;
      fin      <= fin_d;
      done     <= fin;
    end
  end

  // Bus outputs decoded from state; addresses are zero when not strobing.
  always_comb begin
    cs_reg = (A_cpu == REG_ADDR);
    Di_reg = (cs_reg && rd_cpu) ? page_reg : 8'h00;
    rd_src = (state == READ);
    wr_oam = (state == WRITE);
    busy   = (state != IDLE);
    A_src  = rd_src ? {fold_page(page_reg), 8'(idx)} : 16'h0000;
    A_oam  = wr_oam ? (OAM_BASE + 16'(idx)) : 16'h0000;
    Di_oam = wr_oam ? latch : 8'h00;
  end

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module  : tb_oam_dma
// Brief   : Self-checking bench for oam_dma against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] A_cpu = 16'h0000;
  logic [7:0]  Do_cpu = 8'h00;
  logic        wr_cpu = 1'b0;
  logic        rd_cpu = 1'b0;
  logic        cs_reg;
  logic [7:0]  Di_reg;
  logic [15:0] A_src;
  logic        rd_src;
  logic [7:0]  Do_src;
  logic [15:0] A_oam;
  logic [7:0]  Di_oam;
  logic        wr_oam;
  logic        busy;
  logic        done;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  cur_page;
  logic [15:0] first_src, last_src;
  int rd_idx, wr_idx, wr_total, done_cnt, done_at, cyc, busy_cyc, strobe_cnt;

  oam_dma dut (
    .clk(clk), .rst_n(rst_n),
    .A_cpu(A_cpu), .Do_cpu(Do_cpu), .wr_cpu(wr_cpu), .rd_cpu(rd_cpu),
    .cs_reg(cs_reg), .Di_reg(Di_reg),
    .A_src(A_src), .rd_src(rd_src), .Do_src(Do_src),
    .A_oam(A_oam), .Di_oam(Di_oam), .wr_oam(wr_oam),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Source memory answers combinationally.
  assign Do_src = mem[A_src];

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: byte i of page p comes from {folded page, i}.
  function automatic logic [15:0] src_of(input logic [7:0] p, input int i);
    logic [7:0] hi;
    hi = (p >= 8'hE0) ? (p - 8'h20) : p;
    return {hi, i[7:0]};
  endfunction

  // One clock, then compare any bus activity against the transfer model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (busy) busy_cyc++;
    if (rd_src) begin
      if (rd_idx == 0) first_src = A_src;
      last_src = A_src;
      chk("rd_addr", A_src, src_of(cur_page, rd_idx));
      chk("rd_order", rd_idx, wr_idx);
      rd_idx++;
      strobe_cnt++;
    end
    if (wr_oam) begin
      chk("wr_bound", 32'(wr_idx < 160), 1);
      chk("wr_addr", A_oam, 16'hFE00 + 16'(wr_idx));
      chk("wr_data", Di_oam, mem[src_of(cur_page, wr_idx)]);
      chk("wr_order", wr_idx + 1, rd_idx);
      wr_idx++;
      wr_total++;
      strobe_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_at = cyc;
    end
  endtask

  task automatic trigger(input logic [7:0] p);
    cur_page = p;
    rd_idx = 0;
    wr_idx = 0;
    first_src = 16'h0;
    last_src = 16'h0;
    A_cpu = 16'hFF46;
    Do_cpu = p;
    wr_cpu = 1'b1;
    tick();
    wr_cpu = 1'b0;
    A_cpu = 16'h0000;
    Do_cpu = 8'h00;
    cyc = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt > 0), 1);
  endtask

  task automatic full_transfer(input logic [7:0] p, input string tag);
    done_cnt = 0;
    busy_cyc = 0;
    trigger(p);
    wait_done(400);
    chk({tag, "_latency"}, done_at, 322);
    chk({tag, "_writes"}, wr_idx, 160);
    repeat (4) tick();
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_cycles"}, busy_cyc, 321);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);

    // Reset state
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_rd", rd_src, 0);
    chk("rst_wr", wr_oam, 0);
    chk("rst_done", done, 0);
    chk("rst_asrc", A_src, 0);
    chk("rst_aoam", A_oam, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0; rd_idx = 0; wr_idx = 0; wr_total = 0; strobe_cnt = 0;

    // Basic copy from C100 with a known pattern
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    full_transfer(8'hC1, "c1");
    chk("c1_first_src", first_src, 16'hC100);
    chk("c1_last_src", last_src, 16'hC19F);

    // Register readback while a transfer runs
    done_cnt = 0;
    trigger(8'h7E);
    A_cpu = 16'hFF46; rd_cpu = 1'b1;
    #1;
    chk("reg_cs", cs_reg, 1);
    chk("reg_data", Di_reg, 8'h7E);
    A_cpu = 16'hFF45;
    #1;
    chk("reg_cs_other", cs_reg, 0);
    chk("reg_data_other", Di_reg, 8'h00);
    rd_cpu = 1'b0; A_cpu = 16'h0000;
    wait_done(400);
    chk("p7e_latency", done_at, 322);

    // Echo-region folding
    full_transfer(8'hE3, "e3");
    chk("e3_first_src", first_src, 16'hC300);
    chk("e3_last_src", last_src, 16'hC39F);
    for (int t = 0; t < 2; t++) full_transfer(8'($urandom), "rand");

    // Restart after 50 writes
    done_cnt = 0;
    wr_total = 0;
    trigger(8'hC1);
    for (int n = 0; n < 200 && wr_idx < 50; n++) tick();
    chk("restart_point", wr_idx, 50);
    trigger(8'hD0);
    wait_done(400);
    repeat (4) tick();
    chk("restart_total_writes", wr_total, 210);
    chk("restart_done_once", done_cnt, 1);
    chk("restart_latency", done_at, 322);

    // Trigger coinciding with the final write
    done_cnt = 0;
    trigger(8'($urandom));
    for (int n = 0; n < 400 && wr_idx < 160; n++) tick();
    chk("final_point", wr_idx, 160);
    trigger(8'($urandom_range(0, 255)));
    wait_done(400);
    repeat (4) tick();
    chk("final_done_once", done_cnt, 1);
    chk("final_latency", done_at, 322);
    chk("final_writes", wr_idx, 160);

    // Asynchronous reset during the read of byte 80
    trigger(8'($urandom));
    for (int n = 0; n < 400 && rd_idx < 81; n++) tick();
    chk("rst_point_rd", rd_src, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_rd", rd_src, 0);
    chk("arst_asrc", A_src, 0);
    chk("arst_wr", wr_oam, 0);
    chk("arst_aoam", A_oam, 0);
    chk("arst_dioam", Di_oam, 0);
    chk("arst_done", done, 0);
    #2 rst_n = 1'b1;
    strobe_cnt = 0; busy_cyc = 0; done_cnt = 0;
    repeat (20) tick();
    chk("arst_no_strobes", strobe_cnt, 0);
    chk("arst_no_busy", busy_cyc, 0);
    A_cpu = 16'hFF46; rd_cpu = 1'b1;
    #1;
    chk("arst_page", Di_reg, 8'h00);
    rd_cpu = 1'b0; A_cpu = 16'h0000;

    // Writes elsewhere and reads of the register never start a transfer
    strobe_cnt = 0; busy_cyc = 0; done_cnt = 0;
    A_cpu = 16'hFF47; Do_cpu = 8'hC1; wr_cpu = 1'b1;
    tick();
    A_cpu = 16'hFF45;
    tick();
    wr_cpu = 1'b0; A_cpu = 16'hFF46; rd_cpu = 1'b1;
    tick();
    rd_cpu = 1'b0; A_cpu = 16'h0000; Do_cpu = 8'h00;
    repeat (400) tick();
    chk("other_no_strobes", strobe_cnt, 0);
    chk("other_no_busy", busy_cyc, 0);
    chk("other_no_done", done_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
